pipeline_hazard_unit: RTL and testbench

- Parametrised hazard/flush controller for the pipelined nand_cpu.
- Generalises per-stage retain/clear control to NUM_STAGES pipeline registers. Index 0 is the fetch→decode register; higher indices are older.
- Adds a stateful D-cache-miss stall FSM that latches a redirect occurring during a stall, a stall watchdog, and optional performance counters.
- Sits beside fetch and the branch predictor. Drives the pipeline registers and fetch PC override.

---
 rtl/pipeline_hazard_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard and flush controller for the pipelined nand_cpu. It drives per-register
//   retain/clear for NUM_STAGES pipeline registers. Index 0 is fetch->decode, and
//   higher indices are older. It also drives the fetch PC override, and it runs a
//   D-cache-miss stall FSM. That FSM remembers a redirect resolved during the stall
//   and replays it after the stall ends. A watchdog flags stalls that last too long.
//
//   State table:
//     ST_RUN      | normal flow; mispredict and predictor redirects act immediately
//     ST_DSTALL   | D-miss outstanding; younger registers frozen, bubble into MEM_STAGE
//     ST_REDIRECT | one-cycle replay of a redirect captured during the stall
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     bp_override, bp_target   branch predictor redirect request and target
//     fb_*                     branch resolution (valid, predicted/resolved direction
//                              and target, branch PC)
//     i_cache_miss             I-cache miss this cycle (bubble into register 0)
//     d_cache_miss             level, high while a D-miss is outstanding
//     retain, clear            per-register hold / bubble insert (clear dominates)
//     pc_override, pc_target   fetch redirect
//     fetch_stall              hold the fetch PC
//     stall_timeout            sticky watchdog flag
//     mispredict_count,        saturating performance counters, present only
//     dstall_cycles            when HAZARD_PERF_EN is defined
//
//   Build option: define HAZARD_PERF_EN to add the performance counters.

module pipeline_hazard_unit #(
    parameter int PC_W       = 16,
    parameter int NUM_STAGES = 3,
    parameter int BR_STAGE   = 2,
    parameter int MEM_STAGE  = 2,
    parameter int MAX_STALL  = 255,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bp_override,
    input  logic [PC_W-1:0]       bp_target,
    input  logic                  fb_valid,
    input  logic                  fb_predict_taken,
    input  logic                  fb_feedback_taken,
    input  logic [PC_W-1:0]       fb_predict_target,
    input  logic [PC_W-1:0]       fb_feedback_target,
    input  logic [PC_W-1:0]       fb_pc,
    input  logic                  i_cache_miss,
    input  logic                  d_cache_miss,
    output logic [NUM_STAGES-1:0] retain,
    output logic [NUM_STAGES-1:0] clear,
    output logic                  pc_override,
    output logic [PC_W-1:0]       pc_target,
    output logic                  fetch_stall,
    output logic                  stall_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      mispredict_count,
    output logic [CNT_W-1:0]      dstall_cycles
`endif
);

    localparam int SC_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [SC_W-1:0] STALL_MAX  = SC_W'(MAX_STALL);
    localparam logic [SC_W-1:0] STALL_PRE  = SC_W'(MAX_STALL - 1);

    localparam logic [NUM_STAGES-1:0] ONE         = NUM_STAGES'(1);
    // When BR_STAGE == NUM_STAGES the shift wraps to 0, and the subtraction then yields all ones.
    localparam logic [NUM_STAGES-1:0] BR_MASK     = (ONE << BR_STAGE) - ONE;
    localparam logic [NUM_STAGES-1:0] FREEZE_MASK = (ONE << MEM_STAGE) - ONE;
    localparam logic [NUM_STAGES-1:0] BUBBLE_MASK = ONE << MEM_STAGE;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DSTALL   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_pend_valid;
    logic [PC_W-1:0]   r_pend_target;
    logic [SC_W-1:0]   r_stall_cnt;
    logic              r_stall_timeout;

    logic                  w_mispredict;
    logic [PC_W-1:0]       w_recovery;
    logic [NUM_STAGES-1:0] w_retain;
    logic [NUM_STAGES-1:0] w_clear;
    logic                  w_override;
    logic [PC_W-1:0]       w_target;
    logic                  w_fetch_stall;
    logic                  w_capture;
    logic                  w_run_redirect;

    assign w_mispredict = fb_valid &
                          ((fb_predict_taken != fb_feedback_taken) |
                           (fb_feedback_taken & (fb_predict_target != fb_feedback_target)));
    assign w_recovery   = fb_feedback_taken ? fb_feedback_target : (fb_pc + PC_W'(1));

    always_comb begin
        w_retain       = '0;
        w_clear        = '0;
        w_override     = 1'b0;
        w_target       = '0;
        w_fetch_stall  = 1'b0;
        w_capture      = 1'b0;
        w_run_redirect = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (d_cache_miss) begin
                    w_retain      = FREEZE_MASK;
                    w_clear       = BUBBLE_MASK;
                    w_fetch_stall = 1'b1;
                    if (w_mispredict) begin
                        w_clear   = w_clear | BR_MASK;
                        w_capture = 1'b1;
                    end
                end else if (w_mispredict) begin
                    w_override     = 1'b1;
                    w_target       = w_recovery;
                    w_clear        = BR_MASK;
                    w_run_redirect = 1'b1;
                end else begin
                    w_override = bp_override;
                    w_target   = bp_target;
                end
            end
            ST_DSTALL: begin
                if (d_cache_miss) begin
                    w_retain      = FREEZE_MASK;
                    w_clear       = BUBBLE_MASK;
                    w_fetch_stall = 1'b1;
                    // The branch stays retained in the pipe and keeps reporting; take only its first report.
                    if (w_mispredict && !r_pend_valid) begin
                        w_clear   = w_clear | BR_MASK;
                        w_capture = 1'b1;
                    end
                end
            end
            ST_REDIRECT: begin
                w_override = 1'b1;
                w_target   = r_pend_target;
                if (d_cache_miss) begin
                    w_retain      = FREEZE_MASK;
                    w_clear       = BUBBLE_MASK;
                    w_fetch_stall = 1'b1;
                end
            end
            default: ;
        endcase

        if (i_cache_miss) begin
            w_clear[0] = 1'b1;
        end
    end

    assign retain        = w_retain & ~w_clear;
    assign clear         = w_clear;
    assign pc_override   = w_override;
    assign pc_target     = w_target;
    assign fetch_stall   = w_fetch_stall;
    assign stall_timeout = r_stall_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_pend_valid    <= 1'b0;
            r_pend_target   <= '0;
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_recovery;
            end

            case (r_state)
                ST_RUN: begin
                    if (d_cache_miss) begin
                        r_state <= ST_DSTALL;
                    end
                end
                ST_DSTALL: begin
                    if (d_cache_miss) begin
                        if (r_stall_cnt != STALL_MAX) begin
                            r_stall_cnt <= r_stall_cnt + SC_W'(1);
                        end
                        if (r_stall_cnt >= STALL_PRE) begin
                            r_stall_timeout <= 1'b1;
                        end
                    end else begin
                        r_stall_cnt <= '0;
                        r_state     <= r_pend_valid ? ST_REDIRECT : ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    r_pend_valid <= 1'b0;
                    r_state      <= d_cache_miss ? ST_DSTALL : ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_mispredict_count;
    logic [CNT_W-1:0] r_dstall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispredict_count <= '0;
            r_dstall_cycles    <= '0;
        end else begin
            if ((w_capture | w_run_redirect) && !(&r_mispredict_count)) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
            if (w_fetch_stall && !(&r_dstall_cycles)) begin
                r_dstall_cycles <= r_dstall_cycles + CNT_W'(1);
            end
        end
    end

    assign mispredict_count = r_mispredict_count;
    assign dstall_cycles    = r_dstall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench for pipeline_hazard_unit. The DUT is built with MAX_STALL=3, so the
// watchdog fires after a short stall. All other parameters keep their defaults.

module tb_pipeline_hazard_unit;

    typedef struct packed {
        logic [2:0]  retain;
        logic [2:0]  clear;
        logic        ovr;
        logic [15:0] tgt;
        logic        fs;
        logic        to;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        bp_override;
    logic [15:0] bp_target;
    logic        fb_valid;
    logic        fb_predict_taken;
    logic        fb_feedback_taken;
    logic [15:0] fb_predict_target;
    logic [15:0] fb_feedback_target;
    logic [15:0] fb_pc;
    logic        i_cache_miss;
    logic        d_cache_miss;
    logic [2:0]  retain;
    logic [2:0]  clear;
    logic        pc_override;
    logic [15:0] pc_target;
    logic        fetch_stall;
    logic        stall_timeout;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    vec_id   = 0;

    pipeline_hazard_unit #(
        .PC_W(16), .NUM_STAGES(3), .BR_STAGE(2), .MEM_STAGE(2), .MAX_STALL(3), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp_override(bp_override),
        .bp_target(bp_target),
        .fb_valid(fb_valid),
        .fb_predict_taken(fb_predict_taken),
        .fb_feedback_taken(fb_feedback_taken),
        .fb_predict_target(fb_predict_target),
        .fb_feedback_target(fb_feedback_target),
        .fb_pc(fb_pc),
        .i_cache_miss(i_cache_miss),
        .d_cache_miss(d_cache_miss),
        .retain(retain),
        .clear(clear),
        .pc_override(pc_override),
        .pc_target(pc_target),
        .fetch_stall(fetch_stall),
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue the expected response.
    task automatic vec(
        input logic r, input logic bpo, input logic [15:0] bpt,
        input logic fbv, input logic pt, input logic ft,
        input logic [15:0] ptg, input logic [15:0] ftg, input logic [15:0] pc,
        input logic icm, input logic dcm,
        input logic [2:0] e_ret, input logic [2:0] e_clr, input logic e_ovr,
        input logic [15:0] e_tgt, input logic e_fs, input logic e_to);
        resp_t e;
        @(posedge clk);
        #1;
        rst                = r;
        bp_override        = bpo;
        bp_target          = bpt;
        fb_valid           = fbv;
        fb_predict_taken   = pt;
        fb_feedback_taken  = ft;
        fb_predict_target  = ptg;
        fb_feedback_target = ftg;
        fb_pc              = pc;
        i_cache_miss       = icm;
        d_cache_miss       = dcm;
        e.retain = e_ret;
        e.clear  = e_clr;
        e.ovr    = e_ovr;
        e.tgt    = e_tgt;
        e.fs     = e_fs;
        e.to     = e_to;
        exp_q.push_back(e);
    endtask

    // Monitor: compares one response per cycle on the falling edge. pc_target is compared only when a redirect is expected.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec_id++;
                n_checks++;
                if (retain !== e.retain || clear !== e.clear || pc_override !== e.ovr ||
                    fetch_stall !== e.fs || stall_timeout !== e.to ||
                    (e.ovr && pc_target !== e.tgt)) begin
                    n_errors++;
                    $display("FAIL vec%0d: got ret=%b clr=%b ovr=%b tgt=%h fs=%b to=%b, want ret=%b clr=%b ovr=%b tgt=%h fs=%b to=%b",
                             vec_id, retain, clear, pc_override, pc_target, fetch_stall, stall_timeout,
                             e.retain, e.clear, e.ovr, e.tgt, e.fs, e.to);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; bp_override = 1'b0; bp_target = '0; fb_valid = 1'b0;
        fb_predict_taken = 1'b0; fb_feedback_taken = 1'b0; fb_predict_target = '0;
        fb_feedback_target = '0; fb_pc = '0; i_cache_miss = 1'b0; d_cache_miss = 1'b0;
        repeat (2) @(posedge clk);

        //  rst bpo bpt      fbv pt ft ptg      ftg      pc       icm dcm | ret    clr    ovr tgt      fs to
        // Idle after reset
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 0);
        // Predicted taken, actually not taken: fall-through from 0xFFFF wraps to 0
        vec(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 3'b000, 3'b011, 1, 16'h0000, 0, 0);
        // Target mismatch beats the simultaneous predictor redirect
        vec(0, 1, 16'h0500, 1, 1, 1, 16'h0040, 16'h0080, 16'h0010, 0, 0, 3'b000, 3'b011, 1, 16'h0080, 0, 0);
        // Predictor redirect alone
        vec(0, 1, 16'h0123, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 1, 16'h0123, 0, 0);
        // I-cache miss bubbles register 0
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 3'b000, 3'b001, 0, 16'h0000, 0, 0);
        // Correct prediction: nothing happens
        vec(0, 0, 16'h0000, 1, 1, 1, 16'h0200, 16'h0200, 16'h0030, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 0);

        // D-miss for 4 cycles, mispredict on stall cycles 2 and 3
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 0);
        vec(0, 0, 16'h0000, 1, 0, 1, 16'h0000, 16'h1234, 16'h0050, 0, 1, 3'b000, 3'b111, 0, 16'h0000, 1, 0);
        vec(0, 0, 16'h0000, 1, 0, 1, 16'h0000, 16'h1234, 16'h0050, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 0);
        vec(0, 1, 16'h0777, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 0);
        // Miss drops (third DSTALL cycle already fired the watchdog); I-miss still bubbles register 0
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 3'b000, 3'b001, 0, 16'h0000, 0, 1);
        // Replay of the captured redirect; a new mispredict is ignored
        vec(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 3'b000, 3'b000, 1, 16'h1234, 0, 1);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 1);
        // Reset clears the sticky flag without waiting for a clock edge
        vec(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 0);

        // Watchdog with MAX_STALL=3: miss held 5 cycles (1 RUN + 4 DSTALL)
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 0);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 0);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 0);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 0);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 1);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 1);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 1);

        // Mispredict captured on the first stall cycle, then reset mid-stall
        vec(0, 0, 16'h0000, 1, 0, 1, 16'h0000, 16'h0ABC, 16'h0060, 0, 1, 3'b000, 3'b111, 0, 16'h0000, 1, 1);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'b011, 3'b100, 0, 16'h0000, 1, 1);
        vec(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 0);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 0);
        vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 16'h0000, 0, 0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d responses left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
